pack_pixels_to_words: RTL
=========================

Name: pack_pixels_to_words

Overview:
- Parametrised successor to the fixed 12-to-16 packer.
- Sits in the imager datapath between pixel source and USB/DMA sink.
- Packs 8-, 10- or 12-bit pixels, MSB-first, into contiguous WORD_W-bit words; the mode is selected per frame.
- Flushes a zero-padded partial word at frame end, and rewrites the image-type field of the header to match the packing used.

Parameters:
- WORD_W, 16, output word width and input data width.
- TYPE_ADDR, `Image_image_type, index of the header word carrying the image-type field.
- TYPE_BASE, 5'h10, base code written into image_type[4:0]; the final code is TYPE_BASE | pix_mode.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- enable  in  1  packing enable; sampled at FRAME_START
- pix_mode  in  2  packing mode: 0 = 16-bit passthrough, 1 = 8-bit, 2 = 10-bit, 3 = 12-bit; sampled at FRAME_START
- dvi  in  1  input data valid
- dtypei  in  `DTYPE_WIDTH  input data type
- datai  in  WORD_W  input data; pixel occupies datai[pw-1:0]
- dvo  out  1  output valid (registered)
- dtypeo  out  `DTYPE_WIDTH  output data type (registered)
- datao  out  WORD_W  output data (registered)

Behaviour:
- Reset: dvo=0, dtypeo=0, datao=0, state=IDLE, bit accumulator=0, bit count=0, header_addr=0, active mode=0, flush_pend=0.
- Reset mid-frame discards partial bits. No output resumes until the next FRAME_START.
- enable is registered once (en_s) before use.
- At dvi & FRAME_START: latch active_en = en_s and active_mode = pix_mode. Changes to either are ignored until the next FRAME_START.
- State machine:
  - IDLE -> FRAME on FRAME_START.
  - IDLE -> HEADER on HEADER_START.
  - FRAME/HEADER -> IDLE on FRAME_END or HEADER_END.
  - A START seen in any state re-enters its state and clears bit count and header_addr.
- Latency: 1 cycle. Every output is registered from the current input, except the deferred FRAME_END described below.
- FRAME, active_en=1, active_mode!=0, dvi & pixel type (dtypei & `DTYPE_PIXEL_MASK != 0):
  - pw = 8/10/12 for mode 1/2/3.
  - Append datai[pw-1:0] below the existing bits; bit count += pw.
  - If the new count >= WORD_W: datao = top WORD_W accumulated bits, dvo=1, count -= WORD_W, remaining bits kept left-aligned.
  - Otherwise dvo=0.
  - dtypeo = dtypei.
  - Accumulator is 2*WORD_W bits wide; count never exceeds WORD_W-1+pw.
- FRAME_END with count>0:
  - In that cycle, emit datao = residual bits left-aligned and zero-padded, dvo=1, dtypeo = dtype of the last pixel (stored).
  - Set flush_pend and hold FRAME_END. Emit it on the next cycle with datao = its datai and dvo=1.
  - Upstream guarantees dvi=0 in the cycle after FRAME_END.
  - If dvi=1 arrives while flush_pend is set, that beat is dropped. This is a protocol violation; the bench flags it.
- FRAME_END with count=0: passed through normally.
- Non-pixel beats in FRAME (row start/end etc.) pass through: dvo=dvi, datao=datai. The accumulator is unchanged, so packing is continuous across rows.
- HEADER, active_en=1:
  - header_addr increments on each dvi & DTYPE_HEADER beat.
  - When header_addr == TYPE_ADDR: datao = (datai & ~5'h1F) | (TYPE_BASE | active_mode).
  - Otherwise datao = datai.
  - dvo = dvi.
  - Header enable uses the active_en of the previous FRAME_START (en_s before the first frame).
- Passthrough: when active_en=0, active_mode=0, or state IDLE, dvo=dvi, datao=datai, dtypeo=dtypei, and the accumulator is cleared.
- Every pixel produces exact bit packing; there are no gaps between words in a frame.

Test Plan:
- Mode 3, enable=1, pixels 0xABC, 0xDEF, 0x123, 0x456 -> dvo on 2nd, 3rd, 4th pixel with words 0xABCD, 0xEF12, 0x3456; count 0 at end.
- Mode 2, pixels 0x3FF, 0x000 repeated, 8 pixels -> exactly 5 words: 0xFFC0, 0x0FFC, 0x00FF, 0xC00F, 0xFC00.
- Mode 1, pixels 0x12, 0x34, 0x56 then FRAME_END -> 0x1234, then flush word 0x5600, then FRAME_END on the next cycle.
- Mode 3, header beat at TYPE_ADDR = 0x5A3F -> datao 0x5A33; other header words unchanged. With enable=0 -> 0x5A3F.
- pix_mode changed from 3 to 1 mid-frame -> packing stays 12-bit until the next FRAME_START, then becomes 8-bit.
- reset asserted after 1 pixel in mode 3 -> dvo=0, datao=0 next cycle. The next frame's first word contains no stale bits.

Source files
------------

// File: rtl/pack_pixels_to_words.sv
// rtl/pack_pixels_to_words.sv - packs 8/10/12-bit pixels MSB-first into WORD_W-bit words
//
// Ports:
//   clk, reset    clock, synchronous active-high reset
//   enable        packing enable, registered then latched at FRAME_START
//   pix_mode      0 = passthrough, 1 = 8-bit, 2 = 10-bit, 3 = 12-bit; latched at FRAME_START
//   dvi/dtypei/datai  input beat (pixel in datai[pw-1:0])
//   dvo/dtypeo/datao  registered output beat

`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 8
`endif
`ifndef DTYPE_FRAME_START
`define DTYPE_FRAME_START 8'h01
`endif
`ifndef DTYPE_FRAME_END
`define DTYPE_FRAME_END 8'h02
`endif
`ifndef DTYPE_HEADER_START
`define DTYPE_HEADER_START 8'h04
`endif
`ifndef DTYPE_HEADER_END
`define DTYPE_HEADER_END 8'h08
`endif
`ifndef DTYPE_HEADER
`define DTYPE_HEADER 8'h10
`endif
`ifndef DTYPE_PIXEL_MASK
`define DTYPE_PIXEL_MASK 8'h80
`endif
`ifndef Image_image_type
`define Image_image_type 3
`endif

module pack_pixels_to_words #(
  parameter int         WORD_W    = 16,
  parameter int         TYPE_ADDR = `Image_image_type,
  parameter logic [4:0] TYPE_BASE = 5'h10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [1:0]              pix_mode,
  input  logic                    dvi,
  input  logic [`DTYPE_WIDTH-1:0] dtypei,
  input  logic [WORD_W-1:0]       datai,
  output logic                    dvo,
  output logic [`DTYPE_WIDTH-1:0] dtypeo,
  output logic [WORD_W-1:0]       datao
);

  localparam int ACC_W = 2 * WORD_W;
  localparam int CNT_W = $clog2(ACC_W) + 1;
  localparam int DT_W  = `DTYPE_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_FRAME, S_HEADER} state_t;

  state_t            state_q, state_d;
  logic              en_s_q;
  logic              active_en_q, active_en_d;
  logic [1:0]        active_mode_q, active_mode_d;
  logic              seen_frame_q, seen_frame_d;
  logic              flush_pend_q, flush_pend_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [15:0]       hdr_addr_q, hdr_addr_d;
  logic [DT_W-1:0]   last_dtype_q, last_dtype_d;
  logic [DT_W-1:0]   hold_dtype_q, hold_dtype_d;
  logic [WORD_W-1:0] hold_data_q, hold_data_d;
  logic              dvo_q, dvo_d;
  logic [DT_W-1:0]   dtypeo_q, dtypeo_d;
  logic [WORD_W-1:0] datao_q, datao_d;

  // A beat arriving while the deferred FRAME_END is being emitted is dropped.
  logic beat, is_fs, is_fe, is_hs, is_he, is_hdr, is_pix;
  assign beat   = dvi & ~flush_pend_q;
  assign is_fs  = beat && (dtypei == `DTYPE_FRAME_START);
  assign is_fe  = beat && (dtypei == `DTYPE_FRAME_END);
  assign is_hs  = beat && (dtypei == `DTYPE_HEADER_START);
  assign is_he  = beat && (dtypei == `DTYPE_HEADER_END);
  assign is_hdr = beat && (dtypei == `DTYPE_HEADER);
  assign is_pix = beat && ((dtypei & `DTYPE_PIXEL_MASK) != '0);

  logic packing, hdr_en;
  assign packing = (state_q == S_FRAME) && active_en_q && (active_mode_q != 2'd0);
  // Before any frame has been seen, headers follow the live registered enable.
  assign hdr_en  = seen_frame_q ? active_en_q : en_s_q;

  logic [CNT_W-1:0] pw, sum, sh;
  logic [ACC_W-1:0] pix_ext, placed;
  always_comb begin
    case (active_mode_q)
      2'd1:    pw = CNT_W'(8);
      2'd2:    pw = CNT_W'(10);
      2'd3:    pw = CNT_W'(12);
      default: pw = '0;
    endcase
    sum     = cnt_q + pw;
    sh      = CNT_W'(ACC_W) - sum;
    pix_ext = ACC_W'(datai) & ((ACC_W'(1) << pw) - ACC_W'(1));
    // Accumulator is left-aligned: the new pixel lands directly below existing bits.
    placed  = acc_q | (pix_ext << sh);
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (is_fs)               state_d = S_FRAME;
    else if (is_hs)          state_d = S_HEADER;
    else if (is_fe || is_he) state_d = S_IDLE;
  end

  always_comb begin
    dvo_d         = dvi;
    dtypeo_d      = dtypei;
    datao_d       = datai;
    acc_d         = acc_q;
    cnt_d         = cnt_q;
    hdr_addr_d    = hdr_addr_q;
    last_dtype_d  = last_dtype_q;
    hold_dtype_d  = hold_dtype_q;
    hold_data_d   = hold_data_q;
    flush_pend_d  = 1'b0;
    active_en_d   = active_en_q;
    active_mode_d = active_mode_q;
    seen_frame_d  = seen_frame_q;
    if (!packing) begin
      acc_d = '0;
      cnt_d = '0;
    end
    if (flush_pend_q) begin
      dvo_d    = 1'b1;
      dtypeo_d = hold_dtype_q;
      datao_d  = hold_data_q;
    end else if (is_fs || is_hs) begin
      acc_d      = '0;
      cnt_d      = '0;
      hdr_addr_d = '0;
      if (is_fs) begin
        active_en_d   = en_s_q;
        active_mode_d = pix_mode;
        seen_frame_d  = 1'b1;
      end
    end else if (packing && is_pix) begin
      last_dtype_d = dtypei;
      if (sum >= CNT_W'(WORD_W)) begin
        dvo_d   = 1'b1;
        datao_d = placed[ACC_W-1 -: WORD_W];
        acc_d   = placed << WORD_W;
        cnt_d   = sum - CNT_W'(WORD_W);
      end else begin
        dvo_d = 1'b0;
        acc_d = placed;
        cnt_d = sum;
      end
    end else if (packing && is_fe && (cnt_q != '0)) begin
      // Emit the zero-padded residual now and defer FRAME_END by one cycle.
      dvo_d        = 1'b1;
      dtypeo_d     = last_dtype_q;
      datao_d      = acc_q[ACC_W-1 -: WORD_W];
      flush_pend_d = 1'b1;
      hold_dtype_d = dtypei;
      hold_data_d  = datai;
      acc_d        = '0;
      cnt_d        = '0;
    end else if ((state_q == S_HEADER) && hdr_en && is_hdr) begin
      if (hdr_addr_q == 16'(TYPE_ADDR))
        datao_d = {datai[WORD_W-1:5], TYPE_BASE | {3'b000, active_mode_q}};
      hdr_addr_d = hdr_addr_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      en_s_q        <= 1'b0;
      active_en_q   <= 1'b0;
      active_mode_q <= 2'd0;
      seen_frame_q  <= 1'b0;
      flush_pend_q  <= 1'b0;
      acc_q         <= '0;
      cnt_q         <= '0;
      hdr_addr_q    <= '0;
      last_dtype_q  <= '0;
      hold_dtype_q  <= '0;
      hold_data_q   <= '0;
      dvo_q         <= 1'b0;
      dtypeo_q      <= '0;
      datao_q       <= '0;
    end else begin
      en_s_q        <= enable;
      active_en_q   <= active_en_d;
      active_mode_q <= active_mode_d;
      seen_frame_q  <= seen_frame_d;
      flush_pend_q  <= flush_pend_d;
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
      hdr_addr_q    <= hdr_addr_d;
      last_dtype_q  <= last_dtype_d;
      hold_dtype_q  <= hold_dtype_d;
      hold_data_q   <= hold_data_d;
      dvo_q         <= dvo_d;
      dtypeo_q      <= dtypeo_d;
      datao_q       <= datao_d;
    end
  end

  assign dvo    = dvo_q;
  assign dtypeo = dtypeo_q;
  assign datao  = datao_q;

endmodule
